pcm_sample_fifo: RTL and testbench
==================================

// Module: pcm_sample_fifo
// PURPOSE
//   Parametrised synchronous FIFO buffering PCM microphone samples between capture and playback/serial logic.
//   Full 2**ABITS usable depth, occupancy count, programmable almost-full/almost-empty flags and overflow/underflow strobes.
//   Selectable request mode: direct strobes or push-button edge events. Selectable output mode: registered or first-word-fall-through.
// PARAMETERS
//   DBITS     8   data word width
//   ABITS     5   address bits; DEPTH = 2**ABITS words
//   EDGE_MODE 0   0: rd/wr are 1-cycle strobes used directly; 1: rd/wr are levels, one event per falling edge
//   FWFT      0   0: registered read, dout updates 1 cycle after pop; 1: dout shows head word whenever !empty
//   AF_LEVEL  DEPTH-2  almost_full asserted when count >= AF_LEVEL
//   AE_LEVEL  2   almost_empty asserted when count <= AE_LEVEL
// PORTS
//   clock        in   1        single system clock, rising edge
//   reset        in   1        asynchronous, active-high
//   clr          in   1        synchronous flush
//   wr           in   1        write request (strobe or level per EDGE_MODE)
//   din          in   DBITS    write data, sampled on accepted write
//   rd           in   1        read/pop request (strobe or level per EDGE_MODE)
//   dout         out  DBITS    read data
//   dout_valid   out  1        FWFT=0: 1-cycle pulse with new dout; FWFT=1: equals !empty
//   empty        out  1        count == 0
//   full         out  1        count == DEPTH
//   almost_empty out  1        count <= AE_LEVEL
//   almost_full  out  1        count >= AF_LEVEL
//   count        out  ABITS+1  words stored, 0..DEPTH
//   overflow     out  1        1-cycle pulse: write rejected
//   underflow    out  1        1-cycle pulse: read rejected
// BEHAVIOUR
//   Reset: pointers, count, dout, dout_valid, overflow, underflow, edge flops = 0; empty=1, full=0, almost_empty=1, almost_full=0.
//   Requests: EDGE_MODE=0 -> wr_ev=wr, rd_ev=rd. EDGE_MODE=1 -> two-flop chain, ev = ~q1 & q2 (release edge), 2-cycle latency.
//   wr_acc = wr_ev & (!full | rd_acc); rd_acc = rd_ev & !empty. All flags/count registered, valid the cycle after the event.
//   Write: mem[wr_ptr] <= din; wr_ptr wraps DEPTH-1 -> 0 naturally (ABITS-bit counter).
//   Read FWFT=0: dout <= mem[rd_ptr], dout_valid pulses next cycle; dout holds otherwise. FWFT=1: dout = mem[rd_ptr] combinational.
//   count: +1 on write only, -1 on read only, unchanged on both or neither; never leaves 0..DEPTH.
//   Empty + rd + wr: write accepted, read rejected, underflow pulses; count 0->1.
//   Full + rd + wr: both accepted, count stays DEPTH, full stays 1, no overflow.
//   Full + wr only: write dropped, memory/pointers untouched, overflow pulses. Empty + rd only: underflow pulses, dout holds.
//   clr: pointers and count to 0, flags to reset values, overrides rd/wr in same cycle; dout holds; memory contents not cleared.
//   Reset mid-operation: state returns to reset values immediately; first event after release behaves as on an empty FIFO.
//   Flags derived from registered count, so no combinational path from rd/wr to flags.
// STRUCTURE
//   pcm_fifo_pkg: EDGE/STROBE and FWFT/REGISTERED mode constants; clog2-style width helper for count.
//   Sub-module req_edge_detect (clock, reset, level_in, event_out; bypass param): instantiated for rd and wr.
//   Top: memory array, pointer/count register block, next-state combinational block, output mux per FWFT.
// TESTING (ABITS=2 -> DEPTH=4, DBITS=8, AF_LEVEL=3, AE_LEVEL=1, EDGE_MODE=0, FWFT=0 unless noted)
//   Reset with wr held 1 -> after release: empty=1, count=0, dout=0; first strobe writes din normally.
//   Write 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at 3, full at 4; 5th write 0x55 -> overflow pulse, count=4.
//   Read x4 from full -> dout 0x11,0x22,0x33,0x44 one cycle after each rd with dout_valid pulses; 5th rd -> underflow, dout=0x44.
//   Full, rd+wr same cycle with 0x99 -> count=4, full=1, no overflow; drain ends with 0x99. Empty, rd+wr -> count=1, underflow.
//   Fill 3, clr asserted with wr -> count=0, empty=1, write dropped; wrap test: 10 write/read pairs return data in order.
//   EDGE_MODE=1, FWFT=1: hold wr high 5 cycles then low -> exactly one write 2 cycles after release; dout=din, dout_valid=1 without rd.

Source files
------------

// File: rtl/pcm_fifo_pkg.sv
// Shared mode constants, request-op encoding and width helper for the PCM sample FIFO.
package pcm_fifo_pkg;

    localparam int REQ_STROBE     = 0;
    localparam int REQ_EDGE       = 1;
    localparam int OUT_REGISTERED = 0;
    localparam int OUT_FWFT       = 1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pcm_sample_fifo_req_edge_detect.sv
// Request conditioner: passes a strobe straight through, or turns a held level into
// a single event on its release (falling) edge via a two-flop chain.
module req_edge_detect
    import pcm_fifo_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic level_in_i,
    output logic event_out_o
);

    logic q1_q;
    logic q2_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= level_in_i;
            q2_q <= q1_q;
        end
    end

    assign event_out_o = BYPASS ? level_in_i : (~q1_q & q2_q);

endmodule

// File: rtl/pcm_sample_fifo.sv
// Synchronous FIFO for PCM samples with occupancy count, programmable almost flags,
// overflow/underflow strobes, strobe or release-edge requests and registered or FWFT output.
module pcm_sample_fifo
    import pcm_fifo_pkg::*;
#(
    parameter int DBITS     = 8,
    parameter int ABITS     = 5,
    parameter int EDGE_MODE = REQ_STROBE,
    parameter int FWFT      = OUT_REGISTERED,
    parameter int AF_LEVEL  = (1 << ABITS) - 2,
    parameter int AE_LEVEL  = 2,
    localparam int CBITS    = count_width(1 << ABITS)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [DBITS-1:0] din_i,
    input  logic             rd_i,
    output logic [DBITS-1:0] dout_o,
    output logic             dout_valid_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_empty_o,
    output logic             almost_full_o,
    output logic [CBITS-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int             DEPTH  = 1 << ABITS;
    localparam logic [CBITS-1:0] FULL_CNT = CBITS'(DEPTH);
    localparam logic [CBITS-1:0] AF_CNT   = CBITS'(AF_LEVEL);
    localparam logic [CBITS-1:0] AE_CNT   = CBITS'(AE_LEVEL);

    logic [DBITS-1:0] mem [DEPTH];

    logic [1:0] req_lvl;
    logic [1:0] req_ev;
    logic       wr_ev;
    logic       rd_ev;
    logic       wr_acc;
    logic       rd_acc;
    fifo_op_e   op;

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CBITS-1:0] count_q, count_d;
    logic [DBITS-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             aempty_q, aempty_d;
    logic             afull_q, afull_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    assign req_lvl = {wr_i, rd_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            req_edge_detect #(
                .BYPASS(EDGE_MODE == REQ_STROBE)
            ) u_req (
                .clock_i    (clock_i),
                .reset_i    (reset_i),
                .level_in_i (req_lvl[gi]),
                .event_out_o(req_ev[gi])
            );
        end
    endgenerate

    assign wr_ev = req_ev[1];
    assign rd_ev = req_ev[0];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign rd_acc = rd_ev & ~empty_q;
    assign wr_acc = wr_ev & (~full_q | rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (op)
                OP_PUSH: count_d = count_q + CBITS'(1);
                OP_POP:  count_d = count_q - CBITS'(1);
                default: count_d = count_q;
            endcase
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ABITS'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ABITS'(1);
                dout_d   = mem[rd_ptr_q];
            end
            dout_valid_d = rd_acc;
            overflow_d   = wr_ev & ~wr_acc;
            underflow_d  = rd_ev & ~rd_acc;
        end
        empty_d  = (count_d == '0);
        full_d   = (count_d == FULL_CNT);
        aempty_d = (count_d <= AE_CNT);
        afull_d  = (count_d >= AF_CNT);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            aempty_q     <= 1'b1;
            afull_q      <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            aempty_q     <= aempty_d;
            afull_q      <= afull_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage carries no reset so it maps onto RAM; a flush only moves the pointers.
    always_ff @(posedge clock_i) begin
        if (wr_acc && !clr_i) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o         = (FWFT == OUT_FWFT) ? mem[rd_ptr_q] : dout_q;
    assign dout_valid_o   = (FWFT == OUT_FWFT) ? ~empty_q : dout_valid_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Scoreboarded bench for pcm_sample_fifo: a strobe/registered instance and an
// edge/first-word-fall-through instance, both with a 4-deep array.
module tb_pcm_sample_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       clr_a, wr_a, rd_a;
    logic [7:0] din_a, dout_a;
    logic       dv_a, empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
    logic [2:0] count_a;

    logic       clr_b, wr_b, rd_b;
    logic [7:0] din_b, dout_b;
    logic       dv_b, empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
    logic [2:0] count_b;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_d;

    pcm_sample_fifo #(
        .DBITS(8), .ABITS(2), .EDGE_MODE(0), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_dut_a (
        .clock_i(clk), .reset_i(rst), .clr_i(clr_a), .wr_i(wr_a), .din_i(din_a),
        .rd_i(rd_a), .dout_o(dout_a), .dout_valid_o(dv_a), .empty_o(empty_a),
        .full_o(full_a), .almost_empty_o(ae_a), .almost_full_o(af_a),
        .count_o(count_a), .overflow_o(ovf_a), .underflow_o(udf_a)
    );

    pcm_sample_fifo #(
        .DBITS(8), .ABITS(2), .EDGE_MODE(1), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_dut_b (
        .clock_i(clk), .reset_i(rst), .clr_i(clr_b), .wr_i(wr_b), .din_i(din_b),
        .rd_i(rd_b), .dout_o(dout_b), .dout_valid_o(dv_b), .empty_o(empty_b),
        .full_o(full_b), .almost_empty_o(ae_b), .almost_full_o(af_b),
        .count_o(count_b), .overflow_o(ovf_b), .underflow_o(udf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        wr_a = 1'b1;
        din_a = d;
        step();
        wr_a = 1'b0;
    endtask

    task automatic pop_a(input logic [7:0] e);
        sb_q.push_back(e);
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
    endtask

    // Monitor: every dout_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dv_a) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dout_unexpected: got dout_valid with 0x%0h, expected no pulse", dout_a);
            end else begin
                exp_d = sb_q.pop_front();
                chk("dout", 32'(dout_a), 32'(exp_d));
            end
        end
    end

    initial begin
        clr_a = 1'b0; wr_a = 1'b1; rd_a = 1'b0; din_a = 8'h11;
        clr_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; din_b = 8'h00;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_dout", 32'(dout_a), 32'h0);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_ae", 32'(ae_a), 32'd1);
        chk("rst_af", 32'(af_a), 32'd0);
        chk("rst_dv", 32'(dv_a), 32'd0);
        chk("rst_b_dv", 32'(dv_b), 32'd0);

        step();
        wr_a = 1'b0;
        chk("w1_count", 32'(count_a), 32'd1);
        chk("w1_ae", 32'(ae_a), 32'd1);
        push_a(8'h22);
        chk("w2_count", 32'(count_a), 32'd2);
        chk("w2_ae", 32'(ae_a), 32'd0);
        push_a(8'h33);
        chk("w3_count", 32'(count_a), 32'd3);
        chk("w3_af", 32'(af_a), 32'd1);
        chk("w3_full", 32'(full_a), 32'd0);
        push_a(8'h44);
        chk("w4_count", 32'(count_a), 32'd4);
        chk("w4_full", 32'(full_a), 32'd1);
        push_a(8'h55);
        chk("ovf_pulse", 32'(ovf_a), 32'd1);
        chk("ovf_count", 32'(count_a), 32'd4);
        step();
        chk("ovf_clear", 32'(ovf_a), 32'd0);

        pop_a(8'h11);
        chk("r1_count", 32'(count_a), 32'd3);
        chk("r1_full", 32'(full_a), 32'd0);
        pop_a(8'h22);
        pop_a(8'h33);
        pop_a(8'h44);
        chk("r4_empty", 32'(empty_a), 32'd1);
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
        chk("udf_pulse", 32'(udf_a), 32'd1);
        chk("udf_dout_hold", 32'(dout_a), 32'h44);
        chk("udf_dv", 32'(dv_a), 32'd0);
        step();
        chk("udf_clear", 32'(udf_a), 32'd0);

        for (int i = 0; i < 4; i++) push_a(8'hA1 + 8'(i));
        rd_a = 1'b1; wr_a = 1'b1; din_a = 8'h99;
        sb_q.push_back(8'hA1);
        step();
        rd_a = 1'b0; wr_a = 1'b0;
        chk("rw_full_count", 32'(count_a), 32'd4);
        chk("rw_full_full", 32'(full_a), 32'd1);
        chk("rw_full_ovf", 32'(ovf_a), 32'd0);
        pop_a(8'hA2);
        pop_a(8'hA3);
        pop_a(8'hA4);
        pop_a(8'h99);
        chk("rw_drain_count", 32'(count_a), 32'd0);

        rd_a = 1'b1; wr_a = 1'b1; din_a = 8'h77;
        step();
        rd_a = 1'b0; wr_a = 1'b0;
        chk("rw_empty_count", 32'(count_a), 32'd1);
        chk("rw_empty_udf", 32'(udf_a), 32'd1);
        chk("rw_empty_dv", 32'(dv_a), 32'd0);
        pop_a(8'h77);

        push_a(8'h31);
        push_a(8'h32);
        push_a(8'h33);
        chk("pre_clr_count", 32'(count_a), 32'd3);
        clr_a = 1'b1; wr_a = 1'b1; din_a = 8'h34;
        step();
        clr_a = 1'b0; wr_a = 1'b0;
        chk("clr_count", 32'(count_a), 32'd0);
        chk("clr_empty", 32'(empty_a), 32'd1);
        chk("clr_af", 32'(af_a), 32'd0);
        chk("clr_ae", 32'(ae_a), 32'd1);
        chk("clr_dout_hold", 32'(dout_a), 32'h77);

        for (int i = 0; i < 10; i++) begin
            push_a(8'h50 + 8'(i));
            pop_a(8'h50 + 8'(i));
        end
        chk("wrap_count", 32'(count_a), 32'd0);

        push_a(8'hC1);
        push_a(8'hC2);
        chk("pre_rst_count", 32'(count_a), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count_a), 32'd0);
        chk("midrst_empty", 32'(empty_a), 32'd1);
        step();
        rst = 1'b0;
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
        chk("post_rst_udf", 32'(udf_a), 32'd1);
        push_a(8'hD1);
        chk("post_rst_count", 32'(count_a), 32'd1);
        pop_a(8'hD1);

        wr_b = 1'b1; din_b = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("edge_hold_count", 32'(count_b), 32'd0);
        end
        wr_b = 1'b0;
        step();
        chk("edge_e0_count", 32'(count_b), 32'd0);
        step();
        chk("edge_e1_count", 32'(count_b), 32'd1);
        chk("fwft_dout", 32'(dout_b), 32'h5A);
        chk("fwft_dv", 32'(dv_b), 32'd1);
        repeat (3) step();
        chk("edge_single", 32'(count_b), 32'd1);
        rd_b = 1'b1;
        step();
        rd_b = 1'b0;
        chk("edge_rd_e0", 32'(count_b), 32'd1);
        step();
        chk("edge_rd_e1", 32'(count_b), 32'd1);
        step();
        chk("edge_rd_pop", 32'(count_b), 32'd0);
        chk("fwft_dv_empty", 32'(dv_b), 32'd0);

        repeat (2) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
